pb_bus_sequencer: RTL

Parametrised backplane bus sequencer, the next generation of the per-command card-access state machines. It accepts one command through a valid/ready handshake and walks the selected boards in ascending order. For each board it drives board select, address port, active-low RD/WR strobes and the bidirectional data bus with programmable setup, strobe and hold times. It returns captured read data through a valid/ready response channel. It sits between the UART command decoder and the backplane pins.

---
 rtl/pb_bus_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pb_bus_sequencer.sv
// Backplane bus sequencer: one command walks the selected boards with timed RD/WR strobes.
// Optional `PB_BROADCAST_EN enables op 3 as a single all-boards write; otherwise op 3 is rejected.
module pb_bus_sequencer #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int NUM_BOARDS      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int PRE_CYCLES      = 4,
    parameter int SETUP_CYCLES    = 21,
    parameter int STROBE_CYCLES   = 21,
    parameter int HOLD_CYCLES     = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [2:0]                       cmd_port,
    input  logic [NUM_BOARDS-1:0]            cmd_board_mask,
    input  logic [NUM_BOARDS*DATA_WIDTH-1:0] cmd_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [NUM_BOARDS*DATA_WIDTH-1:0] rsp_data,
    output logic [3:0]                       rsp_count,
    output logic                             rsp_error,
    output logic [3:0]                       BOARD_X,
    output logic [2:0]                       AddressPort,
    output logic                             PB_RD,
    output logic                             PB_WR,
    output logic [DATA_WIDTH-1:0]            Data_Out_Port,
    input  logic [DATA_WIDTH-1:0]            Data_In_Port,
    output logic                             data_dir
);

    localparam int CNT_W = 16;
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_ADDR  = 2'd2;
    localparam logic [1:0] OP_BCAST = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_RESPOND
    } state_t;

    state_t                            state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [1:0]                        op_q;
    logic                              bcast_q;
    logic                              err_q;
    logic [2:0]                        port_q;
    logic [NUM_BOARDS-1:0]             rem_q;
    logic [NUM_BOARDS*DATA_WIDTH-1:0]  wdata_q;
    logic [3:0]                        cur_q;
    logic [3:0]                        count_q;

    logic                              cmd_ready_q;
    logic                              rsp_valid_q;
    logic [NUM_BOARDS*DATA_WIDTH-1:0]  rsp_data_q;
    logic [3:0]                        rsp_count_q;
    logic                              rsp_error_q;
    logic [3:0]                        board_x_q;
    logic [2:0]                        addr_q;
    logic                              pb_rd_q;
    logic                              pb_wr_q;
    logic [DATA_WIDTH-1:0]             dout_q;
    logic                              dir_q;

    function automatic logic [3:0] lowest_idx(input logic [NUM_BOARDS-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = 4'(i);
        end
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_BOARDS-1:0] m);
        popcount = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            popcount = popcount + {3'b000, m[i]};
        end
    endfunction

    logic                   accept_w;
    logic                   capture_w;
    logic                   drive_w;
    logic [3:0]             nxt_idx_w;
    logic [3:0]             nxt_board_w;
    logic [DATA_WIDTH-1:0]  nxt_lane_w;
    logic [NUM_BOARDS-1:0]  rem_clr_w;

    assign accept_w    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign capture_w   = (state_q == S_STROBE) && (cnt_q == CNT_W'(STROBE_CYCLES - 1))
                         && ((op_q == OP_READ) || (op_q == OP_ADDR)) && !bcast_q;
    assign drive_w     = (op_q == OP_WRITE) || bcast_q;
    assign nxt_idx_w   = lowest_idx(rem_q);
    assign nxt_board_w = bcast_q ? 4'hF : (nxt_idx_w + 4'd1);
    assign nxt_lane_w  = wdata_q[int'(bcast_q ? 4'd0 : nxt_idx_w) * DATA_WIDTH +: DATA_WIDTH];
    assign rem_clr_w   = rem_q & (rem_q - NUM_BOARDS'(1));

    // Per-board capture lanes; unselected lanes stay at the zero loaded on acceptance.
    logic [DATA_WIDTH-1:0]            cap_q [NUM_BOARDS];
    logic [NUM_BOARDS*DATA_WIDTH-1:0] cap_flat_w;

    for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_lane
        always_ff @(posedge clock) begin
            if (reset || accept_w) begin
                cap_q[gi] <= '0;
            end else if (capture_w && (cur_q == 4'(gi))) begin
                cap_q[gi] <= Data_In_Port;
            end
        end
        assign cap_flat_w[gi*DATA_WIDTH +: DATA_WIDTH] = cap_q[gi];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_WRITE;
            bcast_q     <= 1'b0;
            err_q       <= 1'b0;
            port_q      <= '0;
            rem_q       <= '0;
            wdata_q     <= '0;
            cur_q       <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_count_q <= '0;
            rsp_error_q <= 1'b0;
            board_x_q   <= '0;
            addr_q      <= '0;
            pb_rd_q     <= 1'b1;
            pb_wr_q     <= 1'b1;
            dout_q      <= '0;
            dir_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_w) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        port_q      <= cmd_port;
                        wdata_q     <= cmd_wdata;
                        cnt_q       <= '0;
                        if (cmd_op == OP_BCAST) begin
`ifdef PB_BROADCAST_EN
                            // One pass through the board loop, addressed as board 4'hF.
                            bcast_q <= 1'b1;
                            err_q   <= 1'b0;
                            rem_q   <= NUM_BOARDS'(1);
                            count_q <= 4'd1;
                            state_q <= S_PRE;
`else
                            bcast_q <= 1'b0;
                            err_q   <= 1'b1;
                            rem_q   <= '0;
                            count_q <= 4'd0;
                            state_q <= S_RESPOND;
`endif
                        end else begin
                            bcast_q <= 1'b0;
                            err_q   <= 1'b0;
                            rem_q   <= cmd_board_mask;
                            count_q <= popcount(cmd_board_mask);
                            state_q <= (cmd_board_mask == '0) ? S_RESPOND : S_PRE;
                        end
                    end
                end
                S_PRE, S_NEXT: begin
                    if ((state_q == S_PRE) && (cnt_q != CNT_W'(PRE_CYCLES - 1))) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (rem_q != '0) begin
                        cnt_q     <= '0;
                        cur_q     <= nxt_idx_w;
                        rem_q     <= rem_clr_w;
                        board_x_q <= nxt_board_w;
                        addr_q    <= port_q;
                        dir_q     <= drive_w;
                        if (drive_w) dout_q <= nxt_lane_w;
                        state_q   <= S_SETUP;
                    end else begin
                        state_q <= S_RESPOND;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        pb_wr_q <= !(drive_w || (op_q == OP_ADDR));
                        pb_rd_q <= !(!bcast_q && ((op_q == OP_READ) || (op_q == OP_ADDR)));
                        state_q <= S_STROBE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        pb_wr_q <= 1'b1;
                        pb_rd_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_q     <= '0;
                        board_x_q <= '0;
                        dir_q     <= 1'b0;
                        state_q   <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESPOND: begin
                    // First cycle loads the response; it is then frozen until consumed.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cap_flat_w;
                        rsp_count_q <= count_q;
                        rsp_error_q <= err_q;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_count     = rsp_count_q;
    assign rsp_error     = rsp_error_q;
    assign BOARD_X       = board_x_q;
    assign AddressPort   = addr_q;
    assign PB_RD         = pb_rd_q;
    assign PB_WR         = pb_wr_q;
    assign Data_Out_Port = dout_q;
    assign data_dir      = dir_q;

endmodule
